// File: rtl/io_resp_hub.sv
// Peripheral-side I/O responder: per-channel input holding registers read by the core,
// per-channel output registers drained by consumers. Sticky error flags only with IO_ERRFLAG_EN.
module io_resp_hub #(
    parameter int NUBITS = 32,
    parameter int NUIOIN = 8,
    parameter int NUIOOU = 8,
    parameter int AIW    = $clog2(NUIOIN),
    parameter int AOW    = $clog2(NUIOOU)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_in,
    input  logic [AIW-1:0]           addr_in,
    output logic [NUBITS-1:0]        io_in,
    input  logic                     out_en,
    input  logic [AOW-1:0]           addr_out,
    input  logic [NUBITS-1:0]        data_out,
    input  logic [NUIOIN*NUBITS-1:0] ext_in_data,
    input  logic [NUIOIN-1:0]        ext_in_valid,
    output logic [NUIOIN-1:0]        ext_in_ready,
    output logic [NUIOOU*NUBITS-1:0] ext_out_data,
    output logic [NUIOOU-1:0]        ext_out_valid,
    input  logic [NUIOOU-1:0]        ext_out_ready,
    input  logic                     err_clr,
    output logic [NUIOIN-1:0]        udf_flag,
    output logic [NUIOOU-1:0]        ovf_flag
);

    logic [NUBITS-1:0] hold [NUIOIN];
    logic [NUBITS-1:0] oreg [NUIOOU];
    logic [NUIOIN-1:0] in_vld;
    logic [NUIOIN-1:0] rd_sel;
    logic [NUIOIN-1:0] udf_set;
    logic [NUIOOU-1:0] out_full;
    logic [NUIOOU-1:0] wr_sel;
    logic [NUIOOU-1:0] ovf_set;

    // Out-of-range addresses select nothing, so io_in reads 0 and no state moves.
    always_comb begin
        rd_sel = '0;
        wr_sel = '0;
        io_in  = '0;
        for (int i = 0; i < NUIOIN; i++) begin
            if (addr_in == AIW'(i)) begin
                rd_sel[i] = 1'b1;
                io_in     = hold[i];
            end
        end
        for (int j = 0; j < NUIOOU; j++) begin
            if (addr_out == AOW'(j)) wr_sel[j] = 1'b1;
        end
    end

    assign udf_set = rd_sel & ~in_vld & {NUIOIN{req_in}};
    assign ovf_set = wr_sel & out_full & ~ext_out_ready & {NUIOOU{out_en}};

    assign ext_in_ready  = ~in_vld;
    assign ext_out_valid = out_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_vld <= '0;
            for (int i = 0; i < NUIOIN; i++) hold[i] <= '0;
        end else begin
            for (int i = 0; i < NUIOIN; i++) begin
                if (!in_vld[i] && ext_in_valid[i]) begin
                    hold[i]   <= ext_in_data[i*NUBITS +: NUBITS];
                    in_vld[i] <= 1'b1;
                end else if (in_vld[i] && req_in && rd_sel[i]) begin
                    in_vld[i] <= 1'b0;
                end
            end
        end
    end

    // A write to a full channel lands only if the consumer drains it the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_full <= '0;
            for (int j = 0; j < NUIOOU; j++) oreg[j] <= '0;
        end else begin
            for (int j = 0; j < NUIOOU; j++) begin
                if (out_en && wr_sel[j]) begin
                    if (!out_full[j] || ext_out_ready[j]) begin
                        oreg[j]     <= data_out;
                        out_full[j] <= 1'b1;
                    end
                end else if (out_full[j] && ext_out_ready[j]) begin
                    out_full[j] <= 1'b0;
                end
            end
        end
    end

    for (genvar g = 0; g < NUIOOU; g++) begin : g_pack
        assign ext_out_data[g*NUBITS +: NUBITS] = oreg[g];
    end

`ifdef IO_ERRFLAG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            udf_flag <= '0;
            ovf_flag <= '0;
        end else begin
            udf_flag <= (udf_flag & ~{NUIOIN{err_clr}}) | udf_set;
            ovf_flag <= (ovf_flag & ~{NUIOOU{err_clr}}) | ovf_set;
        end
    end
`else
    logic unused_flag_srcs;
    assign unused_flag_srcs = ^{err_clr, udf_set, ovf_set};
    assign udf_flag = '0;
    assign ovf_flag = '0;
`endif

endmodule

// File: tb/tb_io_resp_hub.sv
module tb_io_resp_hub;

   localparam int NB = 32;
   localparam int NI = 8;
   localparam int NO = 8;
`ifdef IO_ERRFLAG_EN
   localparam logic [7:0] FL = 8'hFF;
`else
   localparam logic [7:0] FL = 8'h00;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             req_in = 1'b0;
   logic [2:0]       addr_in = '0;
   logic [NB-1:0]    io_in;
   logic             out_en = 1'b0;
   logic [2:0]       addr_out = '0;
   logic [NB-1:0]    data_out = '0;
   logic [NI*NB-1:0] ext_in_data = '0;
   logic [NI-1:0]    ext_in_valid = '0;
   logic [NI-1:0]    ext_in_ready;
   logic [NO*NB-1:0] ext_out_data;
   logic [NO-1:0]    ext_out_valid;
   logic [NO-1:0]    ext_out_ready = '0;
   logic             err_clr = 1'b0;
   logic [NI-1:0]    udf_flag;
   logic [NO-1:0]    ovf_flag;

   io_resp_hub #(.NUBITS(NB), .NUIOIN(NI), .NUIOOU(NO)) dut (
      .clk(clk), .rst(rst),
      .req_in(req_in), .addr_in(addr_in), .io_in(io_in),
      .out_en(out_en), .addr_out(addr_out), .data_out(data_out),
      .ext_in_data(ext_in_data), .ext_in_valid(ext_in_valid), .ext_in_ready(ext_in_ready),
      .ext_out_data(ext_out_data), .ext_out_valid(ext_out_valid), .ext_out_ready(ext_out_ready),
      .err_clr(err_clr), .udf_flag(udf_flag), .ovf_flag(ovf_flag)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic report(string name, logic [31:0] act, logic [31:0] exp);
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
   endtask

   initial begin
      step();
      step();
      n_cmp++; if (ext_in_ready !== 8'hFF) report("rst_inrdy", ext_in_ready, 8'hFF);
      n_cmp++; if (ext_out_valid !== 8'h00) report("rst_ovld", ext_out_valid, 8'h00);
      n_cmp++; if (io_in !== 32'h0) report("rst_ioin", io_in, 32'h0);
      rst = 1'b1;
      step();

      ext_in_valid[3] = 1'b1;
      ext_in_data[3*NB +: NB] = 32'h0000_00A5;
      step();
      ext_in_valid = '0;
      n_cmp++; if (ext_in_ready !== 8'hF7) report("fill3_rdy", ext_in_ready, 8'hF7);

      req_in = 1'b1; addr_in = 3'd3;
      #1;
      n_cmp++; if (io_in !== 32'hA5) report("read3_data", io_in, 32'hA5);
      step();
      n_cmp++; if (ext_in_ready !== 8'hFF) report("read3_rdy", ext_in_ready, 8'hFF);

      addr_in = 3'd5;
      #1;
      n_cmp++; if (io_in !== 32'h0) report("udf5_data", io_in, 32'h0);
      step();
      req_in = 1'b0;
      n_cmp++; if (udf_flag !== (FL & 8'h20)) report("udf5_flag", udf_flag, FL & 8'h20);
      n_cmp++; if (ext_in_ready !== 8'hFF) report("udf5_rdy", ext_in_ready, 8'hFF);

      out_en = 1'b1; addr_out = 3'd2; data_out = 32'h1234;
      step();
      out_en = 1'b0;
      n_cmp++; if (ext_out_valid !== 8'h04) report("wr2_vld", ext_out_valid, 8'h04);
      n_cmp++; if (ext_out_data[2*NB +: NB] !== 32'h1234) report("wr2_data", ext_out_data[2*NB +: NB], 32'h1234);

      ext_out_ready[2] = 1'b1;
      step();
      ext_out_ready = '0;
      n_cmp++; if (ext_out_valid !== 8'h00) report("drain2_vld", ext_out_valid, 8'h00);

      out_en = 1'b1; data_out = 32'h99;
      step();
      n_cmp++; if (ext_out_data[2*NB +: NB] !== 32'h99) report("fill2_data", ext_out_data[2*NB +: NB], 32'h99);
      ext_out_ready[2] = 1'b1; data_out = 32'h55;
      step();
      out_en = 1'b0;
      ext_out_ready = '0;
      n_cmp++; if (ext_out_valid !== 8'h04) report("dr_rf2_vld", ext_out_valid, 8'h04);
      n_cmp++; if (ext_out_data[2*NB +: NB] !== 32'h55) report("dr_rf2_data", ext_out_data[2*NB +: NB], 32'h55);
      n_cmp++; if (ovf_flag !== 8'h00) report("dr_rf2_ovf", ovf_flag, 8'h00);

      out_en = 1'b1; addr_out = 3'd6; data_out = 32'h66;
      step();
      data_out = 32'h77;
      step();
      out_en = 1'b0;
      n_cmp++; if (ext_out_data[6*NB +: NB] !== 32'h66) report("ovf6_data", ext_out_data[6*NB +: NB], 32'h66);
      n_cmp++; if (ext_out_valid !== 8'h44) report("ovf6_vld", ext_out_valid, 8'h44);
      n_cmp++; if (ovf_flag !== (FL & 8'h40)) report("ovf6_flag", ovf_flag, FL & 8'h40);

      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      n_cmp++; if (ovf_flag !== 8'h00) report("clr_ovf", ovf_flag, 8'h00);
      n_cmp++; if (udf_flag !== 8'h00) report("clr_udf", udf_flag, 8'h00);

      addr_in = 3'd3;
      #1;
      rst = 1'b0;
      #1;
      n_cmp++; if (ext_in_ready !== 8'hFF) report("mid_rst_inrdy", ext_in_ready, 8'hFF);
      n_cmp++; if (ext_out_valid !== 8'h00) report("mid_rst_ovld", ext_out_valid, 8'h00);
      n_cmp++; if (io_in !== 32'h0) report("mid_rst_ioin", io_in, 32'h0);
      step();
      rst = 1'b1;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/io_resp_hub.md
Name: io_resp_hub

Overview:
- Peripheral-side responder for the processor core's I/O port.
- Serves core input reads (`req_in`/`addr_in`/`io_in`) from per-channel holding registers, which external producers fill over valid/ready handshakes.
- Captures core output writes (`out_en`/`addr_out`/`data_out`) into per-channel output registers, which external consumers drain over valid/ready handshakes.
- Sits between the core top level and the external sensors/actuators.

Parameters:
- NUBITS, 32, data word width; must match the core.
- NUIOIN, 8, number of input channels; minimum 2.
- NUIOOU, 8, number of output channels; minimum 2.
- AIW, $clog2(NUIOIN), input address width; derived, do not override.
- AOW, $clog2(NUIOOU), output address width; derived, do not override.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- req_in  input  1  core consumes input channel addr_in this cycle.
- addr_in  input  AIW  core input channel select.
- io_in  output  NUBITS  data of selected input channel, to core.
- out_en  input  1  core writes data_out to channel addr_out this cycle.
- addr_out  input  AOW  core output channel select.
- data_out  input  NUBITS  core write data.
- ext_in_data  input  NUIOIN*NUBITS  producer data; channel i occupies bits [i*NUBITS +: NUBITS].
- ext_in_valid  input  NUIOIN  producer valid, one bit per channel.
- ext_in_ready  output  NUIOIN  hub can accept, one bit per channel.
- ext_out_data  output  NUIOOU*NUBITS  consumer data, same packing as ext_in_data.
- ext_out_valid  output  NUIOOU  output register holds an untaken word.
- ext_out_ready  input  NUIOOU  consumer takes the word.
- err_clr  input  1  clears sticky error flags (IO_ERRFLAG_EN only).
- udf_flag  output  NUIOIN  sticky read-while-empty, per channel.
- ovf_flag  output  NUIOOU  sticky write-dropped, per channel.

Behaviour:
- Reset (rst=0, asynchronous):
  - all hold/output data registers 0;
  - in_vld=0, so ext_in_ready all 1;
  - ext_out_valid all 0, ext_out_data 0, io_in 0;
  - udf_flag/ovf_flag 0.
- Input channel i, per-channel state EMPTY/FULL:
  - ext_in_ready[i] = ~in_vld[i]. Registered state only; no combinational path from req_in.
  - EMPTY and ext_in_valid[i]=1: hold[i] <= ext_in_data slice, go FULL. Data is readable by the core the next cycle.
  - FULL and req_in=1 with addr_in=i: go EMPTY at the edge; hold[i] keeps its value.
  - Load and consume of the same channel cannot coincide, because ready=0 while FULL.
- Core read path:
  - io_in = hold[addr_in], combinational; zero added latency.
  - The core samples io_in in the req_in cycle.
  - addr_in >= NUIOIN: io_in = 0, no state change.
  - req_in while channel EMPTY: io_in returns the stale hold value, state stays EMPTY, udf_flag[i] set.
- Output channel j, per-channel state EMPTY/FULL:
  - ext_out_valid[j] = out_full[j]; ext_out_data slice = oreg[j].
  - Drain: FULL and ext_out_ready[j]=1 -> EMPTY, unless refilled the same cycle.
  - Write when out_en=1 and addr_out=j:
    - EMPTY: oreg <= data_out, go FULL.
    - FULL with ext_out_ready[j]=1: oreg <= data_out, stay FULL (simultaneous drain and refill, no loss).
    - FULL with ext_out_ready[j]=0: write dropped, oreg unchanged, ovf_flag[j] set.
  - addr_out >= NUIOOU: write ignored, no flag.
- Flags:
  - Set-dominant: if err_clr and a set event coincide, the flag ends 1.
  - err_clr=1 with no set event: flags clear next edge.
- Reset mid-transfer: all pending words are discarded and every channel returns to EMPTY immediately.
- Size: no arithmetic beyond compare and index. NUBITS*(NUIOIN+NUIOOU) data flops plus state bits.

Optional Feature:
- Macro IO_ERRFLAG_EN.
- Defined: udf_flag/ovf_flag registers and err_clr are implemented as specified above.
- Undefined: flag registers are not built; udf_flag and ovf_flag are tied to 0 and err_clr is ignored. Data-path behaviour is identical in both builds.

Test Plan:
- Reset check: assert rst=0 mid-run -> ext_in_ready=8'hFF, ext_out_valid=0, io_in=0 immediately, with no clock edge needed.
- Input fill and read:
  - Drive ext_in_valid[3]=1 with data 32'h0000_00A5 for one cycle -> next cycle ext_in_ready[3]=0.
  - addr_in=3, req_in=1 -> io_in=32'hA5 that cycle; ext_in_ready[3]=1 next cycle.
- Read while empty: req_in=1, addr_in=5 with channel 5 empty -> io_in = prior hold (0 after reset); udf_flag[5]=1 (IO_ERRFLAG_EN).
- Output write with drain:
  - out_en=1, addr_out=2, data_out=32'h1234 -> next cycle ext_out_valid[2]=1, ext_out_data[2]=32'h1234.
  - ext_out_ready[2]=1 -> valid drops next cycle.
- Drain and refill same cycle: channel 2 FULL, ext_out_ready[2]=1, out_en=1 with data 32'h55 -> valid stays 1, data=32'h55, ovf_flag[2]=0.
- Overflow then clear:
  - Channel 6 FULL, ready=0, write 32'h77 -> data unchanged, ovf_flag[6]=1.
  - err_clr=1 with no new event -> ovf_flag[6]=0.
  - Build without IO_ERRFLAG_EN -> flags stay 0 throughout.
